// File: rtl/if_inst_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
//   FS_TO_DS_BUS_WD : width of the IF->ID bus {ex, badvaddr, inst, pc}
//   fs_entry_t      : one queue slot (pc, instruction word, completion flag, exception flag)
package if_inst_queue_pkg;

  localparam int FS_TO_DS_BUS_WD = 97;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_ok;
    logic        ex;
  } fs_entry_t;

endpackage

// File: rtl/if_queue_ctrl.sv
// Pointer and counter control for the fetch queue.
// Ports:
//   clk, resetn         clock, async active-low reset
//   push                entry accepted this cycle
//   push_owed           accepted entry expects an SRAM response
//   pop                 head handed to ID
//   data_ok             SRAM response this cycle
//   flush               exception/eret flush from WB
//   fill_idx            slot that a response fills this cycle
//   wr_ptr/fill_ptr/rd_ptr, occupancy   queue state
//   fill                response goes into the queue (not discarded)
//   allowin, full, waiting              status flags
module if_queue_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             push_owed,
  input  logic             pop,
  input  logic             data_ok,
  input  logic             flush,
  input  logic [PTR_W-1:0] fill_idx,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] fill_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] occupancy,
  output logic             fill,
  output logic             allowin,
  output logic             full,
  output logic             waiting
);

  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] discard;
  logic             drop;
  logic             owed_ok;

  assign drop    = data_ok && (discard != '0);
  assign fill    = data_ok && (discard == '0) && (pending != '0);
  // a response that was actually owed; an orphan one must not underflow discard
  assign owed_ok = data_ok && ((discard != '0) || (pending != '0));

  assign allowin = occupancy < CNT_W'(DEPTH);
  assign full    = occupancy == CNT_W'(DEPTH);
  assign waiting = (pending != '0) || (discard != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pending   <= '0;
      discard   <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pending   <= '0;
      // everything still owed by the SRAM, including a request issued this cycle, is dropped later
      discard   <= discard + pending + CNT_W'(push_owed) - CNT_W'(owed_ok);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (fill) fill_ptr <= fill_idx + PTR_W'(1);
      occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
      pending   <= pending + CNT_W'(push_owed) - CNT_W'(fill);
      if (drop) discard <= discard - CNT_W'(1);
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    data_ok |-> ((pending != '0) || (discard != '0)));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!resetn)
    (occupancy <= CNT_W'(DEPTH + 1)) && (pending <= CNT_W'(DEPTH + 1)) &&
    (discard <= CNT_W'(DEPTH + 1)));

endmodule

// File: rtl/if_inst_queue.sv
// IF stage fetch queue between pre-IF and ID on the SRAM-like instruction port.
// Holds up to DEPTH fetches in program order and pairs in-order data_ok
// responses with the oldest fetch still awaiting its word. A WB flush empties
// the queue and arranges for in-flight responses to be silently dropped.
// Ports:
//   clk, resetn                          clock, async active-low reset
//   pfs_to_fs_valid, pfs_to_fs_pc        push of an issued fetch
//   fs_allowin                           queue has room
//   fs_to_ds_valid, fs_to_ds_bus         head entry to ID {ex, badvaddr, inst, pc}
//   ds_allowin                           ID takes the head
//   inst_sram_rdata, inst_sram_data_ok   SRAM response
//   inst_sram_data_waiting               responses still owed
//   fs_full, fs_valid_o                  occupancy status
//   ws_ex, ws_eret                       flush
// Build option: IF_ADDR_EXC_EN makes misaligned PCs complete immediately as
// address-error entries that owe no SRAM response.
module if_inst_queue
  import if_inst_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       pfs_to_fs_valid,
  input  logic [31:0]                pfs_to_fs_pc,
  output logic                       fs_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic                       ds_allowin,
  input  logic [31:0]                inst_sram_rdata,
  input  logic                       inst_sram_data_ok,
  output logic                       inst_sram_data_waiting,
  output logic                       fs_full,
  output logic                       fs_valid_o,
  input  logic                       ws_ex,
  input  logic                       ws_eret
);

  localparam int PTR_W = $clog2(DEPTH);

  fs_entry_t        entry [DEPTH];
  fs_entry_t        head;
  logic [PTR_W-1:0] wr_ptr, fill_ptr, rd_ptr, fill_idx;
  logic [CNT_W-1:0] occupancy;
  logic             flush, push, push_owed, push_exc, pop, fill;

  assign flush = ws_ex || ws_eret;
  assign push  = pfs_to_fs_valid && fs_allowin;

`ifdef IF_ADDR_EXC_EN
  assign push_exc = pfs_to_fs_pc[1:0] != 2'b00;
`else
  assign push_exc = 1'b0;
`endif
  assign push_owed = push && !push_exc;

  // With address-error entries in the queue, the next slot awaiting data is
  // the oldest incomplete one, which may lie past completed exception slots.
  always_comb begin
    fill_idx = fill_ptr;
`ifdef IF_ADDR_EXC_EN
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < occupancy) && !entry[rd_ptr + PTR_W'(i)].inst_ok)
        fill_idx = rd_ptr + PTR_W'(i);
    end
`endif
  end

  if_queue_ctrl #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .PTR_W(PTR_W)
  ) u_ctrl (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_owed (push_owed),
    .pop       (pop),
    .data_ok   (inst_sram_data_ok),
    .flush     (flush),
    .fill_idx  (fill_idx),
    .wr_ptr    (wr_ptr),
    .fill_ptr  (fill_ptr),
    .rd_ptr    (rd_ptr),
    .occupancy (occupancy),
    .fill      (fill),
    .allowin   (fs_allowin),
    .full      (fs_full),
    .waiting   (inst_sram_data_waiting)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (!flush) begin
      if (push) begin
        entry[wr_ptr].pc      <= pfs_to_fs_pc;
        entry[wr_ptr].inst    <= '0;
        entry[wr_ptr].inst_ok <= push_exc;
        entry[wr_ptr].ex      <= push_exc;
      end
      // push and fill never target the same slot: fill stays inside the occupied window
      if (fill) begin
        entry[fill_idx].inst    <= inst_sram_rdata;
        entry[fill_idx].inst_ok <= 1'b1;
      end
    end
  end

  assign head           = entry[rd_ptr];
  assign fs_valid_o     = occupancy != '0;
  assign fs_to_ds_valid = fs_valid_o && head.inst_ok && !flush;
  assign pop            = fs_to_ds_valid && ds_allowin;
  assign fs_to_ds_bus   = fs_valid_o ? {head.ex, head.pc, head.inst, head.pc} : '0;

endmodule

// File: tb/tb_if_inst_queue.sv
module tb_if_inst_queue;
  import if_inst_queue_pkg::*;

  logic                       clk = 1'b0;
  logic                       resetn;
  logic                       pfs_to_fs_valid;
  logic [31:0]                pfs_to_fs_pc;
  logic                       fs_allowin;
  logic                       fs_to_ds_valid;
  logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
  logic                       ds_allowin;
  logic [31:0]                inst_sram_rdata;
  logic                       inst_sram_data_ok;
  logic                       inst_sram_data_waiting;
  logic                       fs_full;
  logic                       fs_valid_o;
  logic                       ws_ex;
  logic                       ws_eret;

  int checks = 0;
  int errors = 0;

  if_inst_queue #(.DEPTH(2)) dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .pfs_to_fs_valid        (pfs_to_fs_valid),
    .pfs_to_fs_pc           (pfs_to_fs_pc),
    .fs_allowin             (fs_allowin),
    .fs_to_ds_valid         (fs_to_ds_valid),
    .fs_to_ds_bus           (fs_to_ds_bus),
    .ds_allowin             (ds_allowin),
    .inst_sram_rdata        (inst_sram_rdata),
    .inst_sram_data_ok      (inst_sram_data_ok),
    .inst_sram_data_waiting (inst_sram_data_waiting),
    .fs_full                (fs_full),
    .fs_valid_o             (fs_valid_o),
    .ws_ex                  (ws_ex),
    .ws_eret                (ws_eret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_pc    = pc;
    tick();
    pfs_to_fs_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] word);
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = word;
    tick();
    inst_sram_data_ok = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                          input logic ex);
    chk({tag, "_valid"}, 97'(fs_to_ds_valid), 97'(1));
    chk({tag, "_bus"}, 97'(fs_to_ds_bus), {ex, pc, inst, pc});
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_fsvalid"}, 97'(fs_valid_o), 97'(0));
    chk({tag, "_dsvalid"}, 97'(fs_to_ds_valid), 97'(0));
    chk({tag, "_allowin"}, 97'(fs_allowin), 97'(1));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    pfs_to_fs_valid = 1'b0;
    pfs_to_fs_pc = '0;
    ds_allowin = 1'b0;
    inst_sram_rdata = '0;
    inst_sram_data_ok = 1'b0;
    ws_ex = 1'b0;
    ws_eret = 1'b0;
    #23 resetn = 1'b1;
    tick();

    // reset state
    chk_empty("rst");
    chk("rst_full", 97'(fs_full), 97'(0));
    chk("rst_wait", 97'(inst_sram_data_waiting), 97'(0));
    chk("rst_bus", 97'(fs_to_ds_bus), 97'(0));

    // 1: single fetch, one-cycle response, popped by ID
    push(32'hBFC0_0000);
    chk("t1_wait", 97'(inst_sram_data_waiting), 97'(1));
    chk("t1_nodata", 97'(fs_to_ds_valid), 97'(0));
    respond(32'h2408_0001);
    ds_allowin = 1'b1;
    chk_head("t1_head", 32'hBFC0_0000, 32'h2408_0001, 1'b0);
    tick();
    ds_allowin = 1'b0;
    chk_empty("t1_after");
    chk("t1_wait_after", 97'(inst_sram_data_waiting), 97'(0));

    // 2: fill to DEPTH, third push refused, words fill in order
    push(32'h0000_0100);
    push(32'h0000_0104);
    chk("t2_allowin", 97'(fs_allowin), 97'(0));
    chk("t2_full", 97'(fs_full), 97'(1));
    push(32'h0000_0108);
    respond(32'hAAAA_0001);
    respond(32'hAAAA_0002);
    chk("t2_wait", 97'(inst_sram_data_waiting), 97'(0));
    chk_head("t2_h0", 32'h0000_0100, 32'hAAAA_0001, 1'b0);
    ds_allowin = 1'b1;
    tick();
    chk_head("t2_h1", 32'h0000_0104, 32'hAAAA_0002, 1'b0);
    chk("t2_notfull", 97'(fs_full), 97'(0));
    tick();
    ds_allowin = 1'b0;
    chk_empty("t2_after");

    // 3: flush with two responses outstanding
    push(32'h0000_0200);
    push(32'h0000_0204);
    ws_ex = 1'b1;
    tick();
    ws_ex = 1'b0;
    chk_empty("t3_flushed");
    chk("t3_wait", 97'(inst_sram_data_waiting), 97'(1));
    respond(32'hDEAD_0001);
    chk("t3_wait1", 97'(inst_sram_data_waiting), 97'(1));
    chk("t3_drop1", 97'(fs_valid_o), 97'(0));
    respond(32'hDEAD_0002);
    chk("t3_wait2", 97'(inst_sram_data_waiting), 97'(0));
    chk_empty("t3_drop2");
    push(32'hBFC0_0380);
    respond(32'h3C1A_0000);
    chk_head("t3_new", 32'hBFC0_0380, 32'h3C1A_0000, 1'b0);
    ds_allowin = 1'b1;
    tick();
    ds_allowin = 1'b0;
    chk_empty("t3_after");

    // 3b: eret masks a complete head in the flush cycle
    push(32'h0000_0300);
    respond(32'h0000_1111);
    chk("t3b_valid", 97'(fs_to_ds_valid), 97'(1));
    ws_eret = 1'b1;
    #1;
    chk("t3b_masked", 97'(fs_to_ds_valid), 97'(0));
    tick();
    ws_eret = 1'b0;
    chk_empty("t3b_after");
    chk("t3b_wait", 97'(inst_sram_data_waiting), 97'(0));

    // 4: flush + push + data_ok together with one pending -> discard 1
    push(32'h0000_0400);
    pfs_to_fs_valid = 1'b1;
    pfs_to_fs_pc = 32'h0000_0404;
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata = 32'h5555_5555;
    ws_ex = 1'b1;
    tick();
    pfs_to_fs_valid = 1'b0;
    inst_sram_data_ok = 1'b0;
    ws_ex = 1'b0;
    chk_empty("t4_flushed");
    chk("t4_wait", 97'(inst_sram_data_waiting), 97'(1));
    respond(32'h6666_6666);
    chk("t4_wait_done", 97'(inst_sram_data_waiting), 97'(0));
    chk("t4_dropped", 97'(fs_valid_o), 97'(0));
    push(32'h0000_0408);
    respond(32'h7777_7777);
    chk_head("t4_new", 32'h0000_0408, 32'h7777_7777, 1'b0);
    ds_allowin = 1'b1;
    tick();
    ds_allowin = 1'b0;
    chk_empty("t4_after");

    // 5: misaligned PC
    push(32'h0000_0102);
`ifdef IF_ADDR_EXC_EN
    chk("t5_wait", 97'(inst_sram_data_waiting), 97'(0));
    chk_head("t5_exc", 32'h0000_0102, 32'h0000_0000, 1'b1);
`else
    chk("t5_wait", 97'(inst_sram_data_waiting), 97'(1));
    chk("t5_nodata", 97'(fs_to_ds_valid), 97'(0));
    respond(32'h8888_8888);
    chk_head("t5_data", 32'h0000_0102, 32'h8888_8888, 1'b0);
`endif
    ds_allowin = 1'b1;
    tick();
    ds_allowin = 1'b0;
    chk_empty("t5_after");

    // 6: asynchronous reset mid-fill
    push(32'h0000_0500);
    chk("t6_pending", 97'(inst_sram_data_waiting), 97'(1));
    #2 resetn = 1'b0;
    #1;
    chk("t6_fsvalid", 97'(fs_valid_o), 97'(0));
    chk("t6_wait", 97'(inst_sram_data_waiting), 97'(0));
    chk("t6_allowin", 97'(fs_allowin), 97'(1));
    #3 resetn = 1'b1;
    tick();
    chk_empty("t6_after");
    chk("t6_full", 97'(fs_full), 97'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
